// File: rtl/tt_sweep_pkg.sv
// Shared constants for the exhaustive sweep sequencer: state encoding,
// default MISR polynomial and the deepest supported response latency.
package tt_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [15:0] POLY_DEFAULT = 16'h1021;
  localparam int          LAT_MAX      = 4;

endpackage

// File: rtl/tt_sweep_ctrl_misr_accum.sv
// Response accumulator: onset counter plus MISR signature, cleared at sweep
// start and advanced once per sampled function response.
module misr_accum
  import tt_sweep_pkg::*;
#(
  parameter int                 N_IN  = 14,
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = SIG_W'(POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             smp_i,
  input  logic             f_i,
  output logic [N_IN:0]    onset_o,
  output logic [SIG_W-1:0] sig_o
);

  logic [N_IN:0]    onset_q, onset_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    onset_d = onset_q;
    sig_d   = sig_q;
    if (clr_i) begin
      onset_d = '0;
      sig_d   = '0;
    end else if (smp_i) begin
      // N_IN+1 bits holds 2^N_IN, so the count cannot wrap within one sweep
      onset_d = onset_q + (N_IN+1)'(f_i);
      sig_d   = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(f_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onset_q <= '0;
      sig_q   <= '0;
    end else begin
      onset_q <= onset_d;
      sig_q   <= sig_d;
    end
  end

  assign onset_o = onset_q;
  assign sig_o   = sig_q;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweep of a single-output function with onset/MISR capture.
// Optional dual-instance autosymmetry check under TT_SWEEP_AUTOSYM_EN.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int               N_IN  = 14,
  parameter int               LAT   = 0,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             en_i,
  output logic [N_IN-1:0]  vec_o,
  input  logic             f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_IN:0]    onset_o,
  output logic [SIG_W-1:0] sig_o
`ifdef TT_SWEEP_AUTOSYM_EN
  ,
  input  logic [N_IN-1:0]  mask_i,
  output logic [N_IN-1:0]  vecb_o,
  input  logic             fb_i,
  output logic             sym_o
`endif
);

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            go;
  logic            issue;
  logic            smp;
  logic            pipe_empty_d;

  assign go    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue = (state_q == ST_SWEEP) && en_i;

  generate
    if (LAT == 0) begin : g_nolat
      assign smp          = issue;
      assign pipe_empty_d = 1'b1;
    end else begin : g_lat
      logic [LAT-1:0] vld_q, vld_d;

      assign vld_d = LAT'({vld_q, issue});

      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
      end

      assign smp          = vld_q[LAT-1];
      assign pipe_empty_d = ~|vld_d;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_SWEEP: begin
        // all-ones is the final vector: it issues but vec_o stays parked on it
        if (issue) begin
          if (&vec_q) state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
          else        vec_d   = vec_q + N_IN'(1);
        end
      end
      ST_DRAIN: if (pipe_empty_d) state_d = ST_DONE;
      default: ;
    endcase
    if (go) begin
      state_d = ST_SWEEP;
      vec_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  misr_accum #(
    .N_IN  (N_IN),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (go),
    .smp_i   (smp),
    .f_i     (f_i),
    .onset_o (onset_o),
    .sig_o   (sig_o)
  );

  assign vec_o  = vec_q;
  assign busy_o = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done_o = (state_q == ST_DONE);

`ifdef TT_SWEEP_AUTOSYM_EN
  logic [N_IN-1:0] mask_q, mask_d;
  logic            sym_q, sym_d;

  always_comb begin
    mask_d = mask_q;
    sym_d  = sym_q;
    if (go) begin
      mask_d = mask_i;
      sym_d  = 1'b1;
    end else if (smp && (f_i != fb_i)) begin
      sym_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      sym_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      sym_q  <= sym_d;
    end
  end

  assign vecb_o = vec_q ^ mask_q;
  assign sym_o  = sym_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: several small instances (different N_IN/LAT
// and attached functions), one task per scenario.
module tb_tt_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [4:0] start_v = '0;
  logic [4:0] done_v;
  logic [4:0] busy_v;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  // u0: N_IN=3, LAT=0, f is 0 or vec[0]
  logic       sel0 = 1'b0;
  logic [2:0] vec0;
  logic [3:0] onset0;
  logic [15:0] sig0;
  logic       f0;
  assign f0 = sel0 ? vec0[0] : 1'b0;

  // u1: N_IN=3, LAT=1, f = vec[2] through one register
  logic [2:0] vec1;
  logic [3:0] onset1;
  logic [15:0] sig1;
  logic       f1;

  // u2: N_IN=3, LAT=2, f = AND through two registers
  logic [2:0] vec2;
  logic [3:0] onset2;
  logic [15:0] sig2;
  logic       r2a, r2b;

  // u3: N_IN=5, LAT=0, f = x4 | x1 (long enough to exercise MISR feedback)
  logic [4:0] vec3;
  logic [5:0] onset3;
  logic [15:0] sig3;
  logic       f3;
  assign f3 = vec3[4] | vec3[1];

  always @(posedge clk) begin
    f1  <= vec1[2];
    r2a <= &vec2;
    r2b <= r2a;
  end

`ifdef TT_SWEEP_AUTOSYM_EN
  logic [2:0] vecb0, vecb1, vecb2;
  logic [4:0] vecb3;
  logic       sym0, sym1, sym2, sym3;
  logic [3:0] vec4, vecb4, mask4;
  logic [4:0] onset4;
  logic [15:0] sig4;
  logic       sym4, f4, fb4;
  assign f4  = vec4[0] ^ vec4[1];
  assign fb4 = vecb4[0] ^ vecb4[1];
  initial mask4 = 4'b0000;
`else
  assign done_v[4] = 1'b0;
  assign busy_v[4] = 1'b0;
`endif

  tt_sweep_ctrl #(.N_IN(3), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .en_i(en), .vec_o(vec0), .f_i(f0),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .onset_o(onset0), .sig_o(sig0)
`ifdef TT_SWEEP_AUTOSYM_EN
    , .mask_i(3'b000), .vecb_o(vecb0), .fb_i(1'b0), .sym_o(sym0)
`endif
  );

  tt_sweep_ctrl #(.N_IN(3), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .en_i(en), .vec_o(vec1), .f_i(f1),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .onset_o(onset1), .sig_o(sig1)
`ifdef TT_SWEEP_AUTOSYM_EN
    , .mask_i(3'b000), .vecb_o(vecb1), .fb_i(1'b0), .sym_o(sym1)
`endif
  );

  tt_sweep_ctrl #(.N_IN(3), .LAT(2)) u2 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .en_i(en), .vec_o(vec2), .f_i(r2b),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .onset_o(onset2), .sig_o(sig2)
`ifdef TT_SWEEP_AUTOSYM_EN
    , .mask_i(3'b000), .vecb_o(vecb2), .fb_i(1'b0), .sym_o(sym2)
`endif
  );

  tt_sweep_ctrl #(.N_IN(5), .LAT(0)) u3 (
    .clk(clk), .rst(rst), .start_i(start_v[3]), .en_i(en), .vec_o(vec3), .f_i(f3),
    .busy_o(busy_v[3]), .done_o(done_v[3]), .onset_o(onset3), .sig_o(sig3)
`ifdef TT_SWEEP_AUTOSYM_EN
    , .mask_i(5'b00000), .vecb_o(vecb3), .fb_i(1'b0), .sym_o(sym3)
`endif
  );

`ifdef TT_SWEEP_AUTOSYM_EN
  tt_sweep_ctrl #(.N_IN(4), .LAT(0)) u4 (
    .clk(clk), .rst(rst), .start_i(start_v[4]), .en_i(en), .vec_o(vec4), .f_i(f4),
    .busy_o(busy_v[4]), .done_o(done_v[4]), .onset_o(onset4), .sig_o(sig4),
    .mask_i(mask4), .vecb_o(vecb4), .fb_i(fb4), .sym_o(sym4)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int idx);
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
  endtask

  // counts cycles after the start edge until done_o, bounded at 200
  task automatic wait_done(input int idx, output int n);
    n = 0;
    while (!done_v[idx] && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    check_cnt++;
    if ({vec0, onset0, sig0, busy_v[0], done_v[0]} !== 25'd0)
      $display("FAIL reset_u0 got vec=%0d onset=%0d sig=%h busy=%b done=%b want all 0",
               vec0, onset0, sig0, busy_v[0], done_v[0]);
    else pass_cnt++;
    check_cnt++;
    if ({vec2, onset2, sig2, busy_v[2], done_v[2]} !== 25'd0)
      $display("FAIL reset_u2 got vec=%0d onset=%0d sig=%h busy=%b done=%b want all 0",
               vec2, onset2, sig2, busy_v[2], done_v[2]);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    check_cnt++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0)
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy_v[0], done_v[0]);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int n;
    sel0 = 1'b0;
    do_start(0);
    check_cnt++;
    if (busy_v[0] !== 1'b1 || vec0 !== 3'd0)
      $display("FAIL zero_entry got busy=%b vec=%0d want 1 0", busy_v[0], vec0);
    else pass_cnt++;
    wait_done(0, n);
    $display("zero sweep: cycles=%0d onset=%0d sig=%h", n, onset0, sig0);
    check_cnt++;
    if (n !== 8) $display("FAIL zero_cycles got %0d want 8", n); else pass_cnt++;
    check_cnt++;
    if (onset0 !== 4'd0 || sig0 !== 16'h0000)
      $display("FAIL zero_result got onset=%0d sig=%h want 0 0000", onset0, sig0);
    else pass_cnt++;
  endtask

  task automatic test_pattern();
    int n;
    sel0 = 1'b1;
    do_start(0);
    wait_done(0, n);
    $display("pattern sweep: cycles=%0d onset=%0d sig=%h", n, onset0, sig0);
    check_cnt++;
    if (onset0 !== 4'd4) $display("FAIL pattern_onset got %0d want 4", onset0); else pass_cnt++;
    check_cnt++;
    if (sig0 !== 16'h0055) $display("FAIL pattern_sig got %h want 0055", sig0); else pass_cnt++;
    repeat (3) tick();
    check_cnt++;
    if (done_v[0] !== 1'b1 || onset0 !== 4'd4 || sig0 !== 16'h0055 || vec0 !== 3'd7)
      $display("FAIL done_stable got done=%b onset=%0d sig=%h vec=%0d want 1 4 0055 7",
               done_v[0], onset0, sig0, vec0);
    else pass_cnt++;
  endtask

  task automatic test_latency2();
    int n;
    do_start(2);
    wait_done(2, n);
    $display("lat2 sweep: cycles=%0d onset=%0d sig=%h", n, onset2, sig2);
    check_cnt++;
    if (n !== 10) $display("FAIL lat2_busy_cycles got %0d want 10", n); else pass_cnt++;
    check_cnt++;
    if (onset2 !== 4'd1) $display("FAIL lat2_onset got %0d want 1", onset2); else pass_cnt++;
    // a lone 1 in the final sample leaves signature 0001
    check_cnt++;
    if (sig2 !== 16'h0001) $display("FAIL lat2_sig got %h want 0001", sig2); else pass_cnt++;
  endtask

  task automatic test_pause();
    int n;
    do_start(1);
    wait_done(1, n);
    $display("lat1 sweep: cycles=%0d onset=%0d sig=%h", n, onset1, sig1);
    check_cnt++;
    if (n !== 9 || onset1 !== 4'd4 || sig1 !== 16'h000F)
      $display("FAIL lat1_run got cycles=%0d onset=%0d sig=%h want 9 4 000f", n, onset1, sig1);
    else pass_cnt++;
    do_start(1);
    n = 0;
    while (!done_v[1] && n < 200) begin
      en = ~en;
      tick();
      n++;
    end
    en = 1'b1;
    $display("lat1 paused sweep: cycles=%0d onset=%0d sig=%h", n, onset1, sig1);
    check_cnt++;
    if (n !== 17) $display("FAIL pause_cycles got %0d want 17", n); else pass_cnt++;
    check_cnt++;
    if (onset1 !== 4'd4 || sig1 !== 16'h000F)
      $display("FAIL pause_result got onset=%0d sig=%h want 4 000f", onset1, sig1);
    else pass_cnt++;
  endtask

  task automatic test_poly();
    int n;
    int exp_on;
    logic [15:0] exp_sig;
    logic fb;
    exp_on  = 0;
    exp_sig = '0;
    for (int v = 0; v < 32; v++) begin
      fb = v[4] | v[1];
      exp_on += int'(fb);
      exp_sig = {exp_sig[14:0], 1'b0} ^ (exp_sig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, fb};
    end
    do_start(3);
    wait_done(3, n);
    $display("n5 sweep: cycles=%0d onset=%0d sig=%h", n, onset3, sig3);
    check_cnt++;
    if (n !== 32 || onset3 !== 6'(exp_on))
      $display("FAIL n5_onset got cycles=%0d onset=%0d want 32 %0d", n, onset3, exp_on);
    else pass_cnt++;
    check_cnt++;
    if (sig3 !== exp_sig) $display("FAIL n5_sig got %h want %h", sig3, exp_sig); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    sel0 = 1'b1;
    do_start(0);
    n = 0;
    while (vec0 !== 3'd5 && n < 50) begin
      tick();
      n++;
    end
    check_cnt++;
    if (onset0 === 4'd0 || busy_v[0] !== 1'b1)
      $display("FAIL mid_progress got onset=%0d busy=%b want nonzero 1", onset0, busy_v[0]);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if ({vec0, onset0, sig0, busy_v[0], done_v[0]} !== 25'd0)
      $display("FAIL mid_reset got vec=%0d onset=%0d sig=%h busy=%b done=%b want all 0",
               vec0, onset0, sig0, busy_v[0], done_v[0]);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    do_start(0);
    wait_done(0, n);
    $display("post-reset sweep: cycles=%0d onset=%0d sig=%h", n, onset0, sig0);
    check_cnt++;
    if (n !== 8 || onset0 !== 4'd4 || sig0 !== 16'h0055)
      $display("FAIL post_reset got cycles=%0d onset=%0d sig=%h want 8 4 0055", n, onset0, sig0);
    else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    int n;
    sel0 = 1'b1;
    do_start(0);
    repeat (3) tick();
    do_start(0);
    wait_done(0, n);
    n = n + 4;
    $display("restart-while-busy sweep: cycles=%0d onset=%0d sig=%h", n, onset0, sig0);
    check_cnt++;
    if (n !== 8) $display("FAIL restart_cycles got %0d want 8", n); else pass_cnt++;
    check_cnt++;
    if (onset0 !== 4'd4 || sig0 !== 16'h0055)
      $display("FAIL restart_result got onset=%0d sig=%h want 4 0055", onset0, sig0);
    else pass_cnt++;
  endtask

`ifdef TT_SWEEP_AUTOSYM_EN
  task automatic test_autosym();
    int n;
    mask4 = 4'b0011;
    do_start(4);
    wait_done(4, n);
    $display("autosym mask=0011: cycles=%0d sym=%b", n, sym4);
    check_cnt++;
    if (sym4 !== 1'b1) $display("FAIL autosym_0011 got %b want 1", sym4); else pass_cnt++;
    mask4 = 4'b0001;
    do_start(4);
    wait_done(4, n);
    $display("autosym mask=0001: cycles=%0d sym=%b", n, sym4);
    check_cnt++;
    if (sym4 !== 1'b0) $display("FAIL autosym_0001 got %b want 0", sym4); else pass_cnt++;
  endtask
`endif

  initial begin
    repeat (2) tick();
    test_reset();
    test_zero();
    test_pattern();
    test_latency2();
    test_pause();
    test_poly();
    test_reset_mid();
    test_restart_ignored();
`ifdef TT_SWEEP_AUTOSYM_EN
    test_autosym();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
